// File: rtl/hdmi_pkg.sv
// Video timing defaults, upscaler geometry and pixel/flag types shared by the
// transmit (BRAM scan-out) and receive paths.
package hdmi_pkg;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int H_FP_DEF     = 110;
    localparam int H_SYNC_DEF   = 40;
    localparam int H_BP_DEF     = 220;
    localparam int V_ACTIVE_DEF = 720;
    localparam int V_FP_DEF     = 5;
    localparam int V_SYNC_DEF   = 5;
    localparam int V_BP_DEF     = 20;
    localparam int SCALE_DEF    = 4;
    localparam int SRC_W_DEF    = 320;
    localparam int RD_LAT_DEF   = 2;
    localparam int SYNC_POL_DEF = 1;

    localparam int PIX_W = 24;
    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    // Per-pixel control flags, always active-high; polarity is applied at the pins.
    typedef struct packed {
        logic vde;
        logic hsync;
        logic vsync;
        logic sof;
    } vid_flags_t;

    localparam vid_flags_t FLAGS_BLANK = '0;

endpackage

// File: rtl/vid_timing.sv
// Free-running h/v raster counters with raw (active-high, undelayed) region flags.
// While run is low both counters are parked at (0,0).
module vid_timing
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic pclk,
    input  logic rstb,
    input  logic run,
    output logic active,
    output logic line_last,
    output logic frame_last,
    output logic hsync_raw,
    output logic vsync_raw,
    output logic frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SS       = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE       = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS       = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE       = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_wrap, v_wrap;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = '0;
        v_d    = '0;
        if (run) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            v_d = v_q;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge rstb) begin
        if (!rstb) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments only, so every
            // flop samples pre-edge values regardless of statement order.
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign active      = (h_q < H_ACT) && (v_q < V_ACT);
    assign line_last   = (h_q == H_ACT_LAST);
    assign frame_last  = h_wrap && v_wrap;
    assign hsync_raw   = (h_q >= H_SS) && (h_q < H_SE);
    assign vsync_raw   = (v_q >= V_SS) && (v_q < V_SE);
    assign frame_start = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/bram2rgb.sv
// Scans a SCALE-times pixel/line-replicated SRC_W-wide image out of BRAM as timed RGB video.
// Addresses come from a line base plus offset (no multiplier); flags ride a BRAM-matched delay line.
module bram2rgb
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SCALE    = SCALE_DEF,
    parameter int SRC_W    = SRC_W_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int SYNC_POL = SYNC_POL_DEF
) (
    input  logic        pclk,
    input  logic        rstb,
    input  logic        en,
    output logic        bram_en,
    output logic [15:0] bram_addr,
    input  logic [23:0] bram_dout,
    output logic [23:0] rgb,
    output logic        vde,
    output logic        hsync,
    output logic        vsync,
    output logic        start_frame
);
    localparam int DL = RD_LAT + 1;
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SW-1:0] S_LAST  = SW'(SCALE - 1);
    localparam logic [15:0]   SRC_W_C = 16'(SRC_W);
    localparam logic          POL     = (SYNC_POL != 0);

    run_state_t    state_q, state_d;
    logic          live, rd;
    logic          act, line_last, frame_last, hs_raw, vs_raw, sof_raw;
    logic [SW-1:0] xs_q, xs_d, ys_q, ys_d;
    logic [15:0]   offset_q, offset_d, line_base_q, line_base_d;
    logic          bram_en_q, bram_en_d;
    logic [15:0]   bram_addr_q, bram_addr_d;
    vid_flags_t    dl_q [DL];
    vid_flags_t    dl_d [DL];
    vid_flags_t    out_q, out_d;
    pixel_t        rgb_q, rgb_d;

    // Counters only advance while running and en is still high, so the edge that
    // samples en=0 already parks them at (0,0).
    assign live = (state_q == ST_RUN) && en;
    assign rd   = live && act;

    vid_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .pclk        (pclk),
        .rstb        (rstb),
        .run         (live),
        .active      (act),
        .line_last   (line_last),
        .frame_last  (frame_last),
        .hsync_raw   (hs_raw),
        .vsync_raw   (vs_raw),
        .frame_start (sof_raw)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en)  state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        xs_d        = xs_q;
        ys_d        = ys_q;
        offset_d    = offset_q;
        line_base_d = line_base_q;
        if (!live || frame_last) begin
            xs_d        = '0;
            ys_d        = '0;
            offset_d    = '0;
            line_base_d = '0;
        end else if (rd) begin
            if (line_last) begin
                xs_d     = '0;
                offset_d = '0;
                if (ys_q == S_LAST) begin
                    ys_d        = '0;
                    line_base_d = line_base_q + SRC_W_C;
                end else begin
                    ys_d = ys_q + 1'b1;
                end
            end else if (xs_q == S_LAST) begin
                xs_d     = '0;
                offset_d = offset_q + 1'b1;
            end else begin
                xs_d = xs_q + 1'b1;
            end
        end
        bram_en_d   = rd;
        bram_addr_d = rd ? (line_base_q + offset_q) : bram_addr_q;
    end

    // Stage 0 takes a blank entry whenever not live, which flushes the line on en drop.
    always_comb begin
        dl_d[0] = FLAGS_BLANK;
        if (live) begin
            dl_d[0].vde   = act;
            dl_d[0].hsync = hs_raw;
            dl_d[0].vsync = vs_raw;
            dl_d[0].sof   = sof_raw;
        end
        for (int i = 1; i < DL; i++) begin
            dl_d[i] = dl_q[i-1];
        end
        out_d = dl_q[DL-1];
        rgb_d = dl_q[DL-1].vde ? bram_dout : '0;
    end

    always_ff @(posedge pclk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            xs_q        <= '0;
            ys_q        <= '0;
            offset_q    <= '0;
            line_base_q <= '0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            // NOTE: the delay line is a shallow flop array, not a RAM, so it is
            // reset like any register to guarantee blank outputs after reset.
            for (int i = 0; i < DL; i++) begin
                dl_q[i] <= FLAGS_BLANK;
            end
            out_q       <= FLAGS_BLANK;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            offset_q    <= offset_d;
            line_base_q <= line_base_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            for (int i = 0; i < DL; i++) begin
                dl_q[i] <= dl_d[i];
            end
            out_q       <= out_d;
            rgb_q       <= rgb_d;
        end
    end

    assign bram_en     = bram_en_q;
    assign bram_addr   = bram_addr_q;
    assign rgb         = rgb_q;
    assign vde         = out_q.vde;
    assign start_frame = out_q.sof;
    assign hsync       = out_q.hsync ? POL : ~POL;
    assign vsync       = out_q.vsync ? POL : ~POL;

endmodule

// File: tb/tb_bram2rgb.sv
// Bench for bram2rgb: one instance at default 720p timing, one at a tiny raster
// (SCALE=2, RD_LAT=3, active-low syncs) so whole frames fit in a short run.
module tb_bram2rgb;

    typedef struct {
        int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, sc, sw, lat;
        bit pol;
    } tim_t;

    typedef struct {
        logic        en;
        logic [15:0] addr;
        logic [23:0] rgb;
        logic        vde, hs, vs, sof;
    } obs_t;

    typedef struct {
        int vde_rise, vde_fall, vde_rise2, hs_on, hs_off, vs_on, vs_off, sof1, sof2;
        int first_en, first_addr, max_addr, line_start, prev_line_end, blank_en, errs;
    } ev_t;

    localparam tim_t TD = '{ha:1280, hfp:110, hsy:40, hbp:220, va:720, vfp:5, vsy:5, vbp:20,
                            sc:4, sw:320, lat:2, pol:1'b1};
    localparam tim_t TS = '{ha:16, hfp:2, hsy:3, hbp:3, va:8, vfp:1, vsy:2, vbp:1,
                            sc:2, sw:8, lat:3, pol:1'b0};

    logic        pclk, rstb, en_df, en_sm;
    logic        bram_en_df, vde_df, hsync_df, vsync_df, sof_df;
    logic        bram_en_sm, vde_sm, hsync_sm, vsync_sm, sof_sm;
    logic [15:0] bram_addr_df, bram_addr_sm;
    logic [23:0] dout_df, dout_sm, rgb_df, rgb_sm;
    logic [15:0] pd [2];
    logic [15:0] ps [3];
    int          n_checks, n_fail;
    logic [15:0] a8 [8];
    ev_t         ev;

    function automatic logic [23:0] pix(input logic [15:0] a);
        return {a[7:0], a[15:8] ^ 8'h5A, ~a[7:0]};
    endfunction

    bram2rgb u_dut_df (
        .pclk(pclk), .rstb(rstb), .en(en_df), .bram_en(bram_en_df), .bram_addr(bram_addr_df),
        .bram_dout(dout_df), .rgb(rgb_df), .vde(vde_df), .hsync(hsync_df), .vsync(vsync_df),
        .start_frame(sof_df)
    );

    bram2rgb #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2),
        .V_BP(1), .SCALE(2), .SRC_W(8), .RD_LAT(3), .SYNC_POL(0)
    ) u_dut_sm (
        .pclk(pclk), .rstb(rstb), .en(en_sm), .bram_en(bram_en_sm), .bram_addr(bram_addr_sm),
        .bram_dout(dout_sm), .rgb(rgb_sm), .vde(vde_sm), .hsync(hsync_sm), .vsync(vsync_sm),
        .start_frame(sof_sm)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // BRAM models: data for an address appears RD_LAT edges after it is presented.
    always @(posedge pclk) begin
        pd[0] <= bram_addr_df;
        pd[1] <= pd[0];
        ps[0] <= bram_addr_sm;
        ps[1] <= ps[0];
        ps[2] <= ps[1];
    end
    assign dout_df = pix(pd[1]);
    assign dout_sm = pix(ps[2]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic obs_t grab(input bit which);
        obs_t o;
        if (which) begin
            o.en = bram_en_sm; o.addr = bram_addr_sm; o.rgb = rgb_sm;
            o.vde = vde_sm; o.hs = hsync_sm; o.vs = vsync_sm; o.sof = sof_sm;
        end else begin
            o.en = bram_en_df; o.addr = bram_addr_df; o.rgb = rgb_df;
            o.vde = vde_df; o.hs = hsync_df; o.vs = vsync_df; o.sof = sof_df;
        end
        return o;
    endfunction

    // Expected pins at sample s, where the counters held raster position s.
    function automatic obs_t model(input tim_t t, input int s);
        obs_t e;
        int htot, ftot, p, h, v;
        htot = t.ha + t.hfp + t.hsy + t.hbp;
        ftot = htot * (t.va + t.vfp + t.vsy + t.vbp);
        e.en = 1'b0; e.addr = '0; e.rgb = '0; e.vde = 1'b0; e.sof = 1'b0;
        e.hs = !t.pol; e.vs = !t.pol;
        p = s - 1;
        if (p >= 0) begin
            p = p % ftot; h = p % htot; v = p / htot;
            e.en   = (h < t.ha) && (v < t.va);
            e.addr = 16'((v / t.sc) * t.sw + h / t.sc);
        end
        p = s - (t.lat + 2);
        if (p >= 0) begin
            p = p % ftot; h = p % htot; v = p / htot;
            if ((h < t.ha) && (v < t.va)) begin
                e.vde = 1'b1;
                e.rgb = pix(16'((v / t.sc) * t.sw + h / t.sc));
            end
            if (h >= t.ha + t.hfp && h < t.ha + t.hfp + t.hsy) e.hs = t.pol;
            if (v >= t.va + t.vfp && v < t.va + t.vfp + t.vsy) e.vs = t.pol;
            e.sof = (p == 0);
        end
        return e;
    endfunction

    // Samples n negedges starting with the first cycle in RUN; scores every pin and logs edges.
    task automatic run_window(input bit which, input tim_t t, input int n, output ev_t r);
        obs_t o, e;
        logic pv, ph, pvs, hact, vact;
        int   htot;
        htot = t.ha + t.hfp + t.hsy + t.hbp;
        r.vde_rise = -1; r.vde_fall = -1; r.vde_rise2 = -1; r.hs_on = -1; r.hs_off = -1;
        r.vs_on = -1; r.vs_off = -1; r.sof1 = -1; r.sof2 = -1; r.first_en = -1;
        r.first_addr = -1; r.max_addr = -1; r.line_start = -1; r.prev_line_end = -1;
        r.blank_en = 0; r.errs = 0;
        pv = 1'b0; ph = 1'b0; pvs = 1'b0;
        for (int s = 0; s < n; s++) begin
            @(negedge pclk);
            o = grab(which);
            e = model(t, s);
            if (o.en !== e.en || o.vde !== e.vde || o.rgb !== e.rgb || o.hs !== e.hs ||
                o.vs !== e.vs || o.sof !== e.sof || (e.en && o.addr !== e.addr)) r.errs++;
            if (o.en === 1'b1) begin
                if (e.en !== 1'b1) r.blank_en++;
                if (r.first_en < 0) begin r.first_en = s; r.first_addr = int'(o.addr); end
                if (int'(o.addr) > r.max_addr) r.max_addr = int'(o.addr);
                if (s - 1 == t.sc * htot) r.line_start = int'(o.addr);
                if (s - 1 == (t.sc - 1) * htot + t.ha - 1) r.prev_line_end = int'(o.addr);
            end
            if (s >= 1 && s <= 8) a8[s-1] = o.addr;
            if (o.vde === 1'b1 && pv !== 1'b1) begin
                if (r.vde_rise < 0) r.vde_rise = s;
                else if (r.vde_fall >= 0 && r.vde_rise2 < 0) r.vde_rise2 = s;
            end
            if (o.vde !== 1'b1 && pv === 1'b1 && r.vde_fall < 0) r.vde_fall = s;
            hact = (o.hs === t.pol);
            vact = (o.vs === t.pol);
            if (hact && !ph && r.hs_on < 0) r.hs_on = s;
            if (!hact && ph && r.hs_on >= 0 && r.hs_off < 0) r.hs_off = s;
            if (vact && !pvs && r.vs_on < 0) r.vs_on = s;
            if (!vact && pvs && r.vs_on >= 0 && r.vs_off < 0) r.vs_off = s;
            if (o.sof === 1'b1) begin
                if (r.sof1 < 0) r.sof1 = s;
                else if (r.sof2 < 0) r.sof2 = s;
            end
            pv = o.vde; ph = hact; pvs = vact;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstb  = 1'b1;
        en_df = 1'b0;
        en_sm = 1'b0;
        #2 rstb = 1'b0;
        #1;
        check("rst_bram_en", bram_en_df, 0);
        check("rst_bram_addr", bram_addr_df, 0);
        check("rst_rgb", rgb_df, 0);
        check("rst_vde", vde_df, 0);
        check("rst_sof", sof_df, 0);
        check("rst_hsync_pol1", hsync_df, 0);
        check("rst_vsync_pol1", vsync_df, 0);
        check("rst_hsync_pol0", hsync_sm, 1);
        check("rst_vsync_pol0", vsync_sm, 1);
        repeat (3) @(negedge pclk);
        rstb = 1'b1;
        repeat (2) @(negedge pclk);

        // Default raster: startup, line timing, addressing, up to (h=600, v=10).
        en_df = 1'b1;
        run_window(1'b0, TD, 17101, ev);
        check("df_first_vde", ev.vde_rise, 4);
        check("df_first_sof", ev.sof1, 4);
        for (int i = 0; i < 8; i++) check($sformatf("df_addr%0d", i), a8[i], i / 4);
        check("df_vde_high", ev.vde_fall - ev.vde_rise, 1280);
        check("df_vde_low", ev.vde_rise2 - ev.vde_fall, 370);
        check("df_hs_delay", ev.hs_on - ev.vde_fall, 110);
        check("df_hs_width", ev.hs_off - ev.hs_on, 40);
        check("df_line3_end", ev.prev_line_end, 319);
        check("df_line4_start", ev.line_start, 320);
        check("df_blank_en", ev.blank_en, 0);
        check("df_scoreboard", ev.errs, 0);

        // Drop en while the counters sit at h=600 of line 10.
        en_df = 1'b0;
        @(negedge pclk);
        check("drop_bram_en", bram_en_df, 0);
        repeat (2) @(negedge pclk);
        check("drop_inflight_vde", vde_df, 1);
        @(negedge pclk);
        check("drop_vde", vde_df, 0);
        check("drop_rgb", rgb_df, 0);
        repeat (3) @(negedge pclk);
        en_df = 1'b1;
        run_window(1'b0, TD, 20, ev);
        check("restart_first_en", ev.first_en, 1);
        check("restart_first_addr", ev.first_addr, 0);
        check("restart_sof", ev.sof1, 4);
        check("restart_scoreboard", ev.errs, 0);

        // Tiny raster: two full frames plus a few lines.
        en_sm = 1'b1;
        run_window(1'b1, TS, 600, ev);
        check("sm_first_vde", ev.vde_rise, 5);
        check("sm_hs_delay", ev.hs_on - ev.vde_fall, 2);
        check("sm_hs_width", ev.hs_off - ev.hs_on, 3);
        check("sm_vs_start", ev.vs_on, 221);
        check("sm_vs_width", ev.vs_off - ev.vs_on, 48);
        check("sm_sof_period", ev.sof2 - ev.sof1, 288);
        check("sm_max_addr", ev.max_addr, 31);
        check("sm_line1_end", ev.prev_line_end, 7);
        check("sm_line2_start", ev.line_start, 8);
        check("sm_blank_en", ev.blank_en, 0);
        check("sm_scoreboard", ev.errs, 0);

        // Asynchronous reset mid-line, between clock edges.
        check("pre_rst_vde_df", vde_df, 1);
        check("pre_rst_hsync_sm", hsync_sm, 0);
        #2 rstb = 1'b0;
        #1;
        check("async_vde_df", vde_df, 0);
        check("async_rgb_df", rgb_df, 0);
        check("async_hsync_df", hsync_df, 0);
        check("async_hsync_sm", hsync_sm, 1);
        check("async_vsync_sm", vsync_sm, 1);
        check("async_bram_en_df", bram_en_df, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram2rgb.md
BRAM2RGB -- requirements
Module: bram2rgb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE 1280: active pixels per line.
- H_FP 110, H_SYNC 40, H_BP 220: horizontal blanking, in pixels.
- V_ACTIVE 720: active lines per frame.
- V_FP 5, V_SYNC 5, V_BP 20: vertical blanking, in lines.
- SCALE 4: replication factor in both axes.
- SRC_W 320: source frame width in pixels.
- RD_LAT 2: BRAM read latency in cycles.
- SYNC_POL 1: active level of hsync and vsync.
REQ-002 Ports (name, direction, width, meaning), one per line:
- pclk input 1: pixel clock; the only clock.
- rstb input 1: asynchronous, active-low reset.
- en input 1: run enable.
- bram_en output 1: BRAM read enable.
- bram_addr output 16: BRAM read address.
- bram_dout input 24: BRAM read data, {R,G,B}.
- rgb output 24: pixel data.
- vde output 1: video data enable.
- hsync output 1: horizontal sync.
- vsync output 1: vertical sync.
- start_frame output 1: one-cycle pulse at the first active pixel of each frame.

Function
REQ-003 Two-state control FSM with states IDLE and RUN.
- IDLE -> RUN on the first pclk edge that samples en=1.
- RUN -> IDLE on the first pclk edge that samples en=0.
REQ-004 In IDLE, the h and v counters are held at 0 and bram_en is 0.
REQ-005 In RUN, h counts 0..H_total-1 (1649 at defaults) and wraps to 0. v increments on the h wrap, counts 0..V_total-1 (749) and wraps to 0.
REQ-006 The active region is h<H_ACTIVE and v<V_ACTIVE.
REQ-007 Horizontal sync is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
REQ-008 Vertical sync is asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
REQ-009 Addressing: bram_addr = (v/SCALE)*SRC_W + h/SCALE. It is built from a line-base register and an offset counter, with no multiplier.
- The offset increments every SCALE active pixels.
- The line base increments by SRC_W on every SCALE-th active line.
- Both reset to 0 at v wrap.
REQ-010 bram_en is 1 only for counter positions inside the active region. In blanking, bram_addr holds its last value.
REQ-011 Address width: bram_addr is 16 bits. The maximum at defaults is 57599; overflow is not permitted.
REQ-012 Pipeline alignment: rgb, vde, hsync, vsync and start_frame for counter position (h,v) all appear together, exactly RD_LAT+2 cycles after the counters hold (h,v).
- The address and bram_en are registered (+1 cycle).
- The BRAM adds RD_LAT cycles.
- The output register adds +1 cycle.
- Sync and vde flags travel in a matched delay line.
REQ-013 rgb output:
- rgb = bram_dout when the delayed vde is 1.
- rgb = 24'h000000 otherwise.
REQ-014 Sync polarity: inactive sync level = ~SYNC_POL; active level = SYNC_POL.
REQ-015 start_frame is asserted at the output for the position (0,0) only, once per frame.
REQ-016 en falling mid-frame:
- The counters return to (0,0) on the next edge.
- The delay line is flushed with blank entries, so the outputs go blank within RD_LAT+2 cycles with no partial sync glitch beyond the in-flight entries.
REQ-017 en rising: a new frame always starts at (0,0).

Reset
REQ-018 On rstb=0, asynchronously:
- FSM is IDLE.
- Counters, line base and offset are 0.
- bram_en=0 and bram_addr=0.
- rgb=0, vde=0 and start_frame=0.
- hsync and vsync are at their inactive level.
- Every stage of the delay line is blank.
REQ-019 Reset release is recognized synchronously. The first RUN cycle requires rstb=1 and en=1 at a pclk edge.

Structure
REQ-020 Shared package hdmi_pkg holds the default timing constants, SCALE, SRC_W and the 24-bit pixel type, shared with the receive path.
REQ-021 One sub-module, vid_timing, contains the h/v counters and produces the raw active, hsync, vsync and frame-start flags.
REQ-022 bram2rgb contains the FSM, the address generation and the delay/output pipeline.

Verification
REQ-023 Reset release, then en=1: the first vde rise occurs 4 cycles after the first RUN edge. The first bram_addr values are 0,0,0,0,1,1,1,1, and start_frame pulses together with that vde rise.
REQ-024 Line timing: vde is high for 1280 cycles, then low for 370. hsync rises 110 cycles after the vde fall and stays high for 40 cycles.
REQ-025 Addressing:
- Lines 0-3 read addresses 0..319.
- Line 4 starts at 320.
- Line 719 ends at 57599.
- bram_en=0 throughout blanking.
REQ-026 Frame timing: vsync is high for 5 lines, starting at line 725. The start_frame period is exactly 1237500 cycles.
REQ-027 en dropped at h=600 of line 10:
- bram_en=0 on the next cycle.
- vde=0 within 4 cycles.
- After en is reasserted, the first address is 0 and start_frame pulses.
REQ-028 rstb asserted mid-line: with no pclk edge, vde=0, rgb=0 and the syncs go inactive immediately.
